// File: rtl/div_pkg.sv
// Shared encodings for the RV32M divide unit: op codes, op decode helpers and FSM states.
package div_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    // Bit 0 set means unsigned, bit 1 set means remainder is returned.
    localparam int DIV_OP_UNS_BIT = 0;
    localparam int DIV_OP_REM_BIT = 1;

    typedef enum logic [2:0] {
        DIV_ST_IDLE  = 3'd0,
        DIV_ST_ISSUE = 3'd1,
        DIV_ST_WAIT  = 3'd2,
        DIV_ST_DONE  = 3'd3,
        DIV_ST_DRAIN = 3'd4
    } div_state_t;

    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[DIV_OP_UNS_BIT];
    endfunction

    function automatic logic is_rem_op(input logic [1:0] op);
        return op[DIV_OP_REM_BIT];
    endfunction

endpackage

// File: rtl/udiv_core.sv
// Unsigned restoring divider: one quotient bit per cycle, rdy pulses with the final result.
module udiv_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         rdy,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);
    localparam int CW = $clog2(W);

    logic          running;
    logic [CW-1:0] cnt;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  rem_q;
    logic [W-1:0]  div_q;
    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic          fits;

    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        diff    = shifted - {1'b0, div_q};
        fits    = ~diff[W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            rdy     <= 1'b0;
            cnt     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
        end else begin
            rdy <= 1'b0;
            if (vld && !running) begin
                running <= 1'b1;
                cnt     <= '0;
                quo_q   <= dividend;
                rem_q   <= '0;
                div_q   <= divisor;
            end else if (running) begin
                rem_q <= fits ? diff[W-1:0] : shifted[W-1:0];
                quo_q <= {quo_q[W-2:0], fits};
                cnt   <= cnt + 1'b1;
                if (cnt == CW'(W - 1)) begin
                    running <= 1'b0;
                    rdy     <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU wrapper: sign handling, special cases and flush around udiv_core.
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vld_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [RD_W-1:0] rd_idx_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            wb_vld_o,
    output logic [XLEN-1:0] res_o,
    output logic [RD_W-1:0] rd_idx_o
);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state, state_nxt;
    logic            accept;
    logic            op_signed, op_rem, special;
    logic [XLEN-1:0] abs_a, abs_b, special_res;

    logic [1:0]      op_q;
    logic            neg_q, neg_r;
    logic [XLEN-1:0] a_q, b_q;
    logic [RD_W-1:0] rd_q;

    logic            core_vld, core_rdy, capture;
    logic [XLEN-1:0] core_quo, core_rem, core_sel, core_fix;

    always_comb begin
        accept      = vld_i && (state == DIV_ST_IDLE);
        op_signed   = is_signed_op(op_i);
        op_rem      = is_rem_op(op_i);
        abs_a       = (op_signed && rs1_i[XLEN-1]) ? (~rs1_i + 1'b1) : rs1_i;
        abs_b       = (op_signed && rs2_i[XLEN-1]) ? (~rs2_i + 1'b1) : rs2_i;
        special     = 1'b0;
        special_res = '0;
        if (rs2_i == '0) begin
            special     = 1'b1;
            special_res = op_rem ? rs1_i : '1;
        end else if (op_signed && rs1_i == MIN_NEG && rs2_i == '1) begin
            special     = 1'b1;
            special_res = op_rem ? '0 : MIN_NEG;
        end
    end

    always_comb begin
        core_sel = is_rem_op(op_q) ? core_rem : core_quo;
        core_fix = (is_rem_op(op_q) ? neg_r : neg_q) ? (~core_sel + 1'b1) : core_sel;
        core_vld = (state == DIV_ST_ISSUE) && !flush_i;
        capture  = (state == DIV_ST_WAIT) && core_rdy && !flush_i;
        busy_o   = (state != DIV_ST_IDLE);
        wb_vld_o = (state == DIV_ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= DIV_ST_IDLE;
        else     state <= state_nxt;
    end

    // A flush that meets core rdy in WAIT has nothing left to drain, so it returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_ST_IDLE:  if (vld_i) state_nxt = special ? DIV_ST_DONE : DIV_ST_ISSUE;
            DIV_ST_ISSUE: state_nxt = flush_i ? DIV_ST_IDLE : DIV_ST_WAIT;
            DIV_ST_WAIT: begin
                if (core_rdy)     state_nxt = flush_i ? DIV_ST_IDLE : DIV_ST_DONE;
                else if (flush_i) state_nxt = DIV_ST_DRAIN;
            end
            DIV_ST_DONE:  state_nxt = DIV_ST_IDLE;
            DIV_ST_DRAIN: if (core_rdy) state_nxt = DIV_ST_IDLE;
            default:      state_nxt = DIV_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            res_o    <= '0;
            rd_idx_o <= '0;
        end else begin
            if (accept) begin
                op_q  <= op_i;
                rd_q  <= rd_idx_i;
                neg_q <= op_signed & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
                neg_r <= op_signed & rs1_i[XLEN-1];
                a_q   <= abs_a;
                b_q   <= abs_b;
                if (special) begin
                    res_o    <= special_res;
                    rd_idx_o <= rd_idx_i;
                end
            end
            if (capture) begin
                res_o    <= core_fix;
                rd_idx_o <= rd_q;
            end
        end
    end

    udiv_core #(.W(XLEN)) u_core (
        .clk       (clk),
        .rst       (rst),
        .vld       (core_vld),
        .dividend  (a_q),
        .divisor   (b_q),
        .rdy       (core_rdy),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table for results/latency plus flush, hold and reset sequences.
module tb_div_unit;
    import div_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld_i;
    logic [1:0]  op_i;
    logic [31:0] rs1_i, rs2_i;
    logic [4:0]  rd_idx_i;
    logic        flush_i;
    logic        busy_o, wb_vld_o;
    logic [31:0] res_o;
    logic [4:0]  rd_idx_o;

    int n_cmp = 0;
    int n_bad = 0;
    int core_issues = 0;

    div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .vld_i    (vld_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .rd_idx_i (rd_idx_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .wb_vld_o (wb_vld_o),
        .res_o    (res_o),
        .rd_idx_o (rd_idx_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dut.core_vld) core_issues++;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one request once the unit is idle and waits (bounded) for its writeback.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input bit with_flush,
                                 output logic [31:0] res, output logic [4:0] rdo,
                                 output int lat, output int wb_len);
        int guard = 0;
        while (busy_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        op_i = op; rs1_i = a; rs2_i = b; rd_idx_i = rd;
        vld_i = 1'b1; flush_i = with_flush;
        @(negedge clk);
        vld_i = 1'b0; flush_i = 1'b0;
        lat = 1;
        while (!wb_vld_o && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        wb_len = 0;
        res = '0;
        rdo = '0;
        if (!wb_vld_o) begin
            lat = -1;
        end else begin
            res = res_o;
            rdo = rd_idx_o;
            while (wb_vld_o && wb_len < 5) begin
                wb_len++;
                @(negedge clk);
            end
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic [31:0] exp, input bit sp);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.rd = rd; v.exp = exp; v.special = sp;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat, wb_len, issues0, guard, wb_cnt;

        vecs.push_back(mk(DIV_OP_DIVU, 32'd100,        32'd7,          5'd3,  32'd14,         1'b0));
        vecs.push_back(mk(DIV_OP_REMU, 32'd100,        32'd7,          5'd4,  32'd2,          1'b0));
        vecs.push_back(mk(DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd5,  32'hFFFF_FFFD,  1'b0));
        vecs.push_back(mk(DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  1'b0));
        vecs.push_back(mk(DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd7,  32'd1,          1'b0));
        vecs.push_back(mk(DIV_OP_DIV,  32'h8000_0000,  32'd2,          5'd8,  32'hC000_0000,  1'b0));
        vecs.push_back(mk(DIV_OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd9,  32'd14,         1'b0));
        vecs.push_back(mk(DIV_OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd10, 32'hFFFF_FFFE,  1'b0));
        vecs.push_back(mk(DIV_OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'd0,          1'b0));
        vecs.push_back(mk(DIV_OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000,  1'b0));
        vecs.push_back(mk(DIV_OP_DIVU, 32'd5,          32'd0,          5'd13, 32'hFFFF_FFFF,  1'b1));
        vecs.push_back(mk(DIV_OP_REMU, 32'd5,          32'd0,          5'd14, 32'd5,          1'b1));
        vecs.push_back(mk(DIV_OP_DIV,  32'd5,          32'd0,          5'd15, 32'hFFFF_FFFF,  1'b1));
        vecs.push_back(mk(DIV_OP_REM,  32'hFFFF_FFFB,  32'd0,          5'd16, 32'hFFFF_FFFB,  1'b1));
        vecs.push_back(mk(DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 32'h8000_0000,  1'b1));
        vecs.push_back(mk(DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd18, 32'd0,          1'b1));

        rst = 1'b1; vld_i = 1'b0; flush_i = 1'b0; op_i = '0;
        rs1_i = '0; rs2_i = '0; rd_idx_i = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy_o), 32'd0);
        checkOutput("reset_wb",   32'(wb_vld_o), 32'd0);
        checkOutput("reset_res",  res_o, 32'd0);
        checkOutput("reset_rd",   32'(rd_idx_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            issues0 = core_issues;
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b0, res, rdo, lat, wb_len);
            checkOutput($sformatf("vec%0d_res", i), res, vecs[i].exp);
            checkOutput($sformatf("vec%0d_rd", i), 32'(rdo), 32'(vecs[i].rd));
            checkOutput($sformatf("vec%0d_wb_len", i), 32'(wb_len), 32'd1);
            checkOutput($sformatf("vec%0d_res_hold", i), res_o, vecs[i].exp);
            if (vecs[i].special) begin
                checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
                checkOutput($sformatf("vec%0d_core_vld", i), 32'(core_issues - issues0), 32'd0);
            end else begin
                checkOutput($sformatf("vec%0d_latency_ok", i), 32'(lat >= 3 && lat <= 40), 32'd1);
                checkOutput($sformatf("vec%0d_core_vld", i), 32'(core_issues - issues0), 32'd1);
            end
        end

        // Flush while in ISSUE: no core start, straight back to idle, no writeback.
        issues0 = core_issues;
        op_i = DIV_OP_DIVU; rs1_i = 32'd50; rs2_i = 32'd5; rd_idx_i = 5'd20; vld_i = 1'b1;
        @(negedge clk);
        vld_i = 1'b0; flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        checkOutput("flush_issue_busy", 32'(busy_o), 32'd0);
        wb_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (wb_vld_o) wb_cnt++;
        end
        checkOutput("flush_issue_core_vld", 32'(core_issues - issues0), 32'd0);
        checkOutput("flush_issue_wb", 32'(wb_cnt), 32'd0);
        checkOutput("flush_issue_res_kept", res_o, 32'd0);

        // Flush while in WAIT: busy until the core finishes, result discarded.
        issues0 = core_issues;
        op_i = DIV_OP_DIVU; rs1_i = 32'hFFFF_FFFF; rs2_i = 32'd1; rd_idx_i = 5'd21; vld_i = 1'b1;
        @(negedge clk);
        vld_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        checkOutput("flush_wait_busy", 32'(busy_o), 32'd1);
        checkOutput("flush_wait_core_vld", 32'(core_issues - issues0), 32'd1);
        guard = 0; wb_cnt = 0;
        while (busy_o && guard < 200) begin
            if (wb_vld_o) wb_cnt++;
            @(negedge clk);
            guard++;
        end
        checkOutput("flush_wait_busy_held", 32'(guard > 20 && guard < 200), 32'd1);
        checkOutput("flush_wait_wb", 32'(wb_cnt), 32'd0);
        checkOutput("flush_wait_res_kept", res_o, 32'd0);
        applyStimulus(DIV_OP_DIVU, 32'd9, 32'd3, 5'd22, 1'b0, res, rdo, lat, wb_len);
        checkOutput("after_drain_res", res, 32'd3);
        checkOutput("after_drain_rd", 32'(rdo), 32'd22);

        // Flush together with a new request in IDLE: the request still runs.
        applyStimulus(DIV_OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd23, 1'b1, res, rdo, lat, wb_len);
        checkOutput("flush_accept_res", res, 32'hFFFF_FFF2);
        checkOutput("flush_accept_rd", 32'(rdo), 32'd23);

        // vld_i held while busy with changing operands: only requests seen in IDLE count.
        op_i = DIV_OP_DIVU; rs1_i = 32'd100; rs2_i = 32'd10; rd_idx_i = 5'd24; vld_i = 1'b1;
        @(negedge clk);
        guard = 0;
        while (!wb_vld_o && guard < 200) begin
            rs1_i = 32'd1000 + 32'(guard); rs2_i = 32'd3; rd_idx_i = 5'(guard);
            @(negedge clk);
            guard++;
        end
        checkOutput("held_first_res", res_o, 32'd10);
        checkOutput("held_first_rd", 32'(rd_idx_o), 32'd24);
        rs1_i = 32'd81; rs2_i = 32'd9; rd_idx_i = 5'd25;
        @(negedge clk);
        checkOutput("held_idle_gap", 32'(busy_o), 32'd0);
        @(negedge clk);
        vld_i = 1'b0;
        guard = 0;
        while (!wb_vld_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("held_second_res", res_o, 32'd9);
        checkOutput("held_second_rd", 32'(rd_idx_o), 32'd25);
        @(negedge clk);

        // Reset asserted in WAIT clears everything on the next cycle.
        applyStimulus(DIV_OP_DIVU, 32'd100, 32'd7, 5'd26, 1'b0, res, rdo, lat, wb_len);
        op_i = DIV_OP_DIVU; rs1_i = 32'd1000; rs2_i = 32'd10; rd_idx_i = 5'd27; vld_i = 1'b1;
        @(negedge clk);
        vld_i = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_wait_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_wait_wb", 32'(wb_vld_o), 32'd0);
        checkOutput("rst_wait_res", res_o, 32'd0);
        checkOutput("rst_wait_rd", 32'(rd_idx_o), 32'd0);
        applyStimulus(DIV_OP_DIVU, 32'd9, 32'd3, 5'd28, 1'b0, res, rdo, lat, wb_len);
        checkOutput("after_rst_res", res, 32'd3);
        checkOutput("after_rst_rd", 32'(rdo), 32'd28);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
